// File: rtl/uart_buffer_streamer.sv
// rtl/uart_buffer_streamer.sv - drains one ping-pong buffer per buffer_ready pulse into a framed 8N1 UART stream
// Frame: SYNC0 SYNC1 seq drops, then BUFFER_DEPTH samples of 3 bytes each, MSB byte first.
module uart_buffer_streamer #(
    parameter int         CLK_HZ       = 27000000,
    parameter int         BAUD         = 115200,
    parameter int         BUFFER_DEPTH = 256,
    parameter logic [7:0] SYNC0        = 8'hA5,
    parameter logic [7:0] SYNC1        = 8'h5A
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] ram_read_data_i,
    input  logic        ram_read_valid_i,
    output logic        ram_read_ready_o,
    input  logic        ram_buffer_ready_i,
    output logic        uart_tx_o,
    output logic        busy_o,
    output logic [7:0]  drop_count_o
);
    localparam int BAUD_DIV = CLK_HZ / BAUD;
    localparam int BW       = $clog2(BAUD_DIV + 1);
    localparam int CW       = $clog2(BUFFER_DEPTH + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DEPTH     = CW'(BUFFER_DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] HDR   = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] SEND  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [8:0]    tx_shift;
    logic [23:0]   sample;
    logic [CW-1:0] sample_cnt;
    logic [7:0]    seq;
    logic [7:0]    drops_lat;
    logic [7:0]    hdr_next;
    logic [7:0]    smp_next;
    logic          bit_end;
    logic          last_byte;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_byte = (state == HDR) ? (byte_idx == 2'd3) : (byte_idx == 2'd2);

    // Byte that follows the one currently on the line
    always_comb begin
        hdr_next = SYNC1;
        case (byte_idx)
            2'd0:    hdr_next = SYNC1;
            2'd1:    hdr_next = seq;
            default: hdr_next = drops_lat;
        endcase
        smp_next = (byte_idx == 2'd0) ? sample[15:8] : sample[7:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            baud_cnt         <= '0;
            bit_idx          <= '0;
            byte_idx         <= '0;
            tx_shift         <= '1;
            sample           <= '0;
            sample_cnt       <= '0;
            seq              <= '0;
            drops_lat        <= '0;
            drop_count_o     <= '0;
            busy_o           <= 1'b0;
            ram_read_ready_o <= 1'b0;
            uart_tx_o        <= 1'b1;
        end else begin
            if (ram_buffer_ready_i && state != IDLE && drop_count_o != 8'hFF)
                drop_count_o <= drop_count_o + 8'd1;
            case (state)
                IDLE: if (ram_buffer_ready_i) begin
                    state        <= HDR;
                    busy_o       <= 1'b1;
                    drops_lat    <= drop_count_o;
                    drop_count_o <= '0;
                    byte_idx     <= '0;
                    bit_idx      <= '0;
                    baud_cnt     <= '0;
                    tx_shift     <= {1'b1, SYNC0};
                    uart_tx_o    <= 1'b0;
                end
                HDR, SEND: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx != 4'd9) begin
                            // Shifting in ones leaves the stop bit at the bottom after the data bits
                            uart_tx_o <= tx_shift[0];
                            tx_shift  <= {1'b1, tx_shift[8:1]};
                            bit_idx   <= bit_idx + 4'd1;
                        end else if (!last_byte) begin
                            byte_idx  <= byte_idx + 2'd1;
                            bit_idx   <= '0;
                            uart_tx_o <= 1'b0;
                            tx_shift  <= {1'b1, (state == HDR) ? hdr_next : smp_next};
                        end else if (state == HDR || sample_cnt < DEPTH) begin
                            state            <= FETCH;
                            ram_read_ready_o <= 1'b1;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: if (ram_read_ready_o && ram_read_valid_i) begin
                    state            <= SEND;
                    ram_read_ready_o <= 1'b0;
                    sample           <= ram_read_data_i;
                    sample_cnt       <= sample_cnt + 1'b1;
                    byte_idx         <= '0;
                    bit_idx          <= '0;
                    baud_cnt         <= '0;
                    tx_shift         <= {1'b1, ram_read_data_i[23:16]};
                    uart_tx_o        <= 1'b0;
                end
                DONE: begin
                    state      <= IDLE;
                    seq        <= seq + 8'd1;
                    sample_cnt <= '0;
                    busy_o     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_buffer_streamer.sv
// tb/tb_uart_buffer_streamer.sv - randomized bench for uart_buffer_streamer against a timeline model
module tb_uart_buffer_streamer;
    localparam int D      = 4;
    localparam int DEPTH  = 8;
    localparam int BYTE_T = 10 * D;
    localparam int FRAME_CYC = 4 * BYTE_T + DEPTH * (3 * BYTE_T + 1) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pulse = 1'b0;
    logic        valid = 1'b0;
    logic [23:0] data = '0;
    logic        ready;
    logic        tx;
    logic        busy;
    logic [7:0]  drop;

    always #5 clk = ~clk;

    uart_buffer_streamer #(
        .CLK_HZ(40), .BAUD(10), .BUFFER_DEPTH(DEPTH), .SYNC0(8'hA5), .SYNC1(8'h5A)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ram_read_data_i(data), .ram_read_valid_i(valid), .ram_read_ready_o(ready),
        .ram_buffer_ready_i(pulse), .uart_tx_o(tx), .busy_o(busy), .drop_count_o(drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: frame timeline derived from byte/bit durations
    int         cyc = 0;
    bit         m_active = 0;
    bit         m_ready = 0;
    int         m_end = -1;
    int         m_ready_on = -1;
    int         m_seq = 0;
    int         m_drops = 0;
    int         m_samples = 0;
    int         burst_start = 0;
    logic [7:0] burst[$];
    int         hdr_pos[$];
    logic [7:0] byte_log[$];
    int         busy_len[$];
    int         valid_mode = 0;

    always @(negedge clk) begin
        data = 24'($urandom());
        case (valid_mode)
            0:       valid = 1'b1;
            1:       valid = 1'($urandom());
            default: valid = 1'b0;
        endcase
    end

    initial begin
        logic        s_rst, s_pulse, s_valid;
        logic [23:0] s_data;
        logic        tx_exp, prev_busy;
        logic [7:0]  bv, d_byte;
        int          t, b, rise, d_cnt;
        bit          d_busy;
        prev_busy = 0; rise = 0; d_busy = 0; d_cnt = 0; d_byte = '0;
        forever begin
            @(posedge clk);
            s_rst = rst; s_pulse = pulse; s_valid = valid; s_data = data;
            @(negedge clk);
            cyc++;
            if (s_rst) begin
                m_active = 0; m_ready = 0; m_seq = 0; m_drops = 0; m_samples = 0;
                m_end = -1; m_ready_on = -1; burst.delete(); d_busy = 0;
            end else begin
                if (s_pulse) begin
                    if (m_active) begin
                        if (m_drops < 255) m_drops++;
                    end else begin
                        m_active = 1;
                        hdr_pos.push_back(byte_log.size());
                        burst.delete();
                        burst_start = cyc;
                        burst.push_back(8'hA5);
                        burst.push_back(8'h5A);
                        burst.push_back(8'(m_seq));
                        burst.push_back(8'(m_drops));
                        m_drops = 0;
                        m_samples = 0;
                        m_ready_on = cyc + 4 * BYTE_T;
                        m_end = -1;
                    end
                end
                if (m_ready && s_valid) begin
                    m_ready = 0;
                    m_samples++;
                    burst.delete();
                    burst_start = cyc;
                    burst.push_back(s_data[23:16]);
                    burst.push_back(s_data[15:8]);
                    burst.push_back(s_data[7:0]);
                    if (m_samples < DEPTH) m_ready_on = cyc + 3 * BYTE_T;
                    else m_end = cyc + 3 * BYTE_T + 1;
                end
                if (m_active && cyc == m_ready_on) m_ready = 1;
                if (m_active && cyc == m_end) begin
                    m_active = 0;
                    m_seq = (m_seq + 1) % 256;
                end
            end
            t = cyc - burst_start;
            tx_exp = 1'b1;
            if (t >= 0 && t < burst.size() * BYTE_T) begin
                b  = (t % BYTE_T) / D;
                bv = burst[t / BYTE_T];
                tx_exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bv[b-1];
            end
            check("tx", tx, tx_exp);
            check("busy", busy, m_active);
            check("ready", ready, m_ready);
            check("drops", drop, m_drops);

            // Independent 8N1 decoder sampling mid-bit
            if (s_rst) d_busy = 0;
            else if (!d_busy) begin
                if (tx === 1'b0) begin d_busy = 1; d_cnt = 0; end
            end else begin
                d_cnt++;
                for (int k = 1; k <= 8; k++)
                    if (d_cnt == D / 2 + k * D) d_byte[k-1] = tx;
                if (d_cnt == D / 2 + 9 * D) begin
                    check("stop_bit", tx, 1'b1);
                    byte_log.push_back(d_byte);
                    d_busy = 0;
                end
            end

            if (busy && !prev_busy) rise = cyc;
            if (!busy && prev_busy) busy_len.push_back(cyc - rise);
            prev_busy = busy;
        end
    end

    task automatic pulse_once();
        pulse = 1'b1;
        @(negedge clk);
        pulse = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_active && n < 5000) begin @(negedge clk); n++; end
        checks++;
        if (m_active) begin errors++; $display("FAIL wait_idle: frame did not end within 5000 cycles"); end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_hdr(input int f, input logic [7:0] s, input logic [7:0] d);
        logic [7:0] exp[4];
        exp[0] = 8'hA5; exp[1] = 8'h5A; exp[2] = s; exp[3] = d;
        for (int i = 0; i < 4; i++)
            check($sformatf("hdr%0d_byte%0d", f, i),
                  (f < hdr_pos.size() && hdr_pos[f] + i < byte_log.size()) ? byte_log[hdr_pos[f] + i] : 32'hxxxx_xxxx,
                  exp[i]);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_drops", drop, 8'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Frame 0: valid always high, three buffers skipped
        valid_mode = 0;
        pulse_once();
        repeat (50) @(negedge clk);
        for (int i = 1; i <= 3; i++) begin
            pulse_once();
            check("drops_during_f0", drop, i);
            repeat (100) @(negedge clk);
        end
        wait_idle();
        check("f0_busy_len", busy_len.size() > 0 ? busy_len[0] : -1, FRAME_CYC);
        check("f0_drops_after", drop, 8'd3);
        check_hdr(0, 8'h00, 8'h00);

        // Frame 1: random valid plus a long stall in FETCH
        pulse_once();
        check("f1_drops_cleared", drop, 8'd0);
        valid_mode = 1;
        begin
            int n = 0;
            while (!(m_samples >= 3 && m_ready) && n < 5000) begin @(negedge clk); n++; end
        end
        valid_mode = 2;
        repeat (300) @(negedge clk);
        check("stall_ready", ready, 1'b1);
        check("stall_tx", tx, 1'b1);
        valid_mode = 1;
        wait_idle();
        check_hdr(1, 8'h01, 8'h03);

        // Frame 2: 300 skipped buffers saturate the counter
        valid_mode = 0;
        pulse_once();
        pulse = 1'b1;
        repeat (300) @(negedge clk);
        pulse = 1'b0;
        @(negedge clk);
        check("drops_saturated", drop, 8'hFF);
        wait_idle();

        // Frame 3: reset in the middle of sample 5's second byte
        pulse_once();
        begin
            int n = 0;
            while (m_samples < 5 && n < 5000) begin @(negedge clk); n++; end
        end
        repeat (BYTE_T + 3 * D) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", tx, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ready", ready, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check_hdr(3, 8'h03, 8'hFF);

        // Frame 4: sequence restarts after reset
        pulse_once();
        wait_idle();
        check_hdr(4, 8'h00, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: bench did not complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
